// File: rtl/button_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// button_debouncer_pkg
//   Shared definitions for the button debouncer: the 2-bit FSM state
//   encoding, plus two small decode helpers used to generate the registered
//   out/busy flags from the next-state value.
// ---------------------------------------------------------------------------
package button_debouncer_pkg;

    // LOW / HIGH are the settled levels; the *_CHK states qualify a
    // candidate change while out still shows the previously accepted level.
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    // Debounced level implied by a state: the old level is kept while a
    // falling change is being qualified.
    function automatic logic state_level(input db_state_t s);
        return (s == HIGH) || (s == FALL_CHK);
    endfunction

    // A candidate change is under qualification.
    function automatic logic state_busy(input db_state_t s);
        return (s == RISE_CHK) || (s == FALL_CHK);
    endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input. Reusable for any
//   asynchronous level input; only q may be consumed by downstream logic.
//
//   clk : system clock
//   rst : asynchronous active-low reset, clears both flops to 0
//   d   : asynchronous input level
//   q   : synchronized level (output of the second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // stage_reg[0] may go metastable; stage_reg[1] gives it a full cycle
    // to resolve before anyone looks at it.
    logic [1:0] stage_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= 2'b00;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Debounces a bouncing mechanical button level. The raw input is
//   synchronized, then a four-state FSM accepts a level change only after
//   the synchronized input has held the new level for STABLE_CYCLES
//   consecutive cycles.
//
//   Parameters
//     STABLE_CYCLES : consecutive stable cycles needed to accept a change
//     CNT_W         : stability counter width (STABLE_CYCLES <= 2^CNT_W-1)
//
//   Ports
//     clk  : system clock
//     rst  : asynchronous active-low reset
//     in   : raw asynchronous button level
//     out  : debounced level, registered
//     busy : high while a candidate change is being qualified, registered
//
//   A clean step on in reaches out STABLE_CYCLES+3 edges later: two edges
//   through the synchronizer, one to enter *_CHK, STABLE_CYCLES to qualify.
// ---------------------------------------------------------------------------
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic busy
);

    // Elaboration-time guard on the counter range.
    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_params
            $error("button_debouncer: STABLE_CYCLES out of range for CNT_W");
        end
    endgenerate

    // Terminal count: reaching it with the candidate level still present
    // completes the qualification, so cnt never exceeds this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             in_s;
    db_state_t        state_reg;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             out_reg;
    logic             busy_reg;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (in_s)
    );

    // State, counter and output flags. out/busy are decoded from the next
    // state into dedicated flops so they change cleanly with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= state_level(state_next);
            busy_reg  <= state_busy(state_next);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            LOW: begin
                if (in_s) begin
                    state_next = RISE_CHK;
                    cnt_next   = '0;
                end
            end
            RISE_CHK: begin
                if (!in_s) begin
                    // Bounce: give up and keep the old level.
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!in_s) begin
                    state_next = FALL_CHK;
                    cnt_next   = '0;
                end
            end
            FALL_CHK: begin
                if (in_s) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
            end
        endcase
    end

    assign out  = out_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//   Self-checking bench for button_debouncer with STABLE_CYCLES=4, CNT_W=3.
//   Per-cycle vectors {in, expected out, expected busy} are applied from a
//   table; reset and chain behaviour are exercised by hand-written sequences.
//   Inputs are driven and outputs sampled 1 time unit after each posedge.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 3;

    logic clk;
    logic rst;
    logic in;
    logic out;
    logic busy;

    int checks = 0;
    int errors = 0;

    // Downstream rising-edge detector model fed by out.
    logic prev_out = 1'b0;
    int   pulses   = 0;

    typedef struct {
        logic in_v;
        logic exp_out;
        logic exp_busy;
        int   seg;
    } vec_t;

    vec_t vecs[$];

    button_debouncer #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .out  (out),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; sample 1 unit later and feed the edge detector.
    task automatic step();
        @(posedge clk);
        #1;
        if (out && !prev_out) pulses++;
        prev_out = out;
    endtask

    function automatic void add(input logic i, input logic o, input logic b, input int seg);
        vec_t v;
        v.in_v     = i;
        v.exp_out  = o;
        v.exp_busy = b;
        v.seg      = seg;
        vecs.push_back(v);
    endfunction

    initial begin
        // Record k drives in before edge k; expectations are after edge k.
        // Seg 1: clean rise; busy edges 3..6, out from edge 7.
        for (int k = 1; k <= 10; k++) add(1'b1, k >= 7, k >= 3 && k <= 6, 1);
        // Seg 2: 4-cycle gap while HIGH; qualification aborts, out stays 1.
        for (int k = 1; k <= 10; k++) add(k > 4, 1'b1, k >= 3 && k <= 6, 2);
        // Seg 3: clean fall; out drops at edge 7.
        for (int k = 1; k <= 10; k++) add(1'b0, k <= 6, k >= 3 && k <= 6, 3);
        // Seg 4: bounce 1x3, 0x2, 1x2, then 0 held.
        add(1'b1, 1'b0, 1'b0, 4);
        add(1'b1, 1'b0, 1'b0, 4);
        add(1'b1, 1'b0, 1'b1, 4);
        add(1'b0, 1'b0, 1'b1, 4);
        add(1'b0, 1'b0, 1'b1, 4);
        add(1'b1, 1'b0, 1'b0, 4);
        add(1'b1, 1'b0, 1'b0, 4);
        add(1'b0, 1'b0, 1'b1, 4);
        add(1'b0, 1'b0, 1'b1, 4);
        add(1'b0, 1'b0, 1'b0, 4);
        add(1'b0, 1'b0, 1'b0, 4);
        add(1'b0, 1'b0, 1'b0, 4);
        // Seg 5: pulse of exactly STABLE_CYCLES cycles is rejected.
        for (int k = 1; k <= 10; k++) add(k <= 4, 1'b0, k >= 3 && k <= 6, 5);
        // Seg 6: pulse of STABLE_CYCLES+1 cycles is accepted, then falls.
        for (int k = 1; k <= 14; k++)
            add(k <= 5, k >= 7 && k <= 11, (k >= 3 && k <= 6) || (k >= 8 && k <= 11), 6);

        // Reset with in=1, before any clock edge.
        rst = 1'b0;
        in  = 1'b1;
        #2;
        check("reset_out_noclk", out, 1'b0);
        check("reset_busy_noclk", busy, 1'b0);
        step();
        step();
        check("reset_out_clocked", out, 1'b0);
        check("reset_busy_clocked", busy, 1'b0);
        in  = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();
        prev_out = out;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            in = vecs[i].in_v;
            step();
            $display("vec %0d seg %0d in=%b out=%b busy=%b (exp out=%b busy=%b)",
                     i, vecs[i].seg, vecs[i].in_v, out, busy,
                     vecs[i].exp_out, vecs[i].exp_busy);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end

        // Asynchronous reset while HIGH, between clock edges.
        in = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("async_pre_out", out, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        $display("async reset mid-cycle: out=%b busy=%b", out, busy);
        check("async_out", out, 1'b0);
        check("async_busy", busy, 1'b0);
        in = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();
        prev_out = out;

        // Reset during RISE_CHK discards the partial count; in held 1.
        in = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        check("midrst_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_busy_now", busy, 1'b0);
        check("midrst_out_now", out, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            step();
            check($sformatf("midrst_hold%0d_out", k), out, 1'b0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            $display("post-release edge %0d: out=%b busy=%b", k, out, busy);
            check($sformatf("release_e%0d_out", k), out, k >= 7);
            check($sformatf("release_e%0d_busy", k), busy, k >= 3 && k <= 6);
        end

        // Chain into edge detector: two bouncing presses -> two pulses.
        in = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("chain_start_low", out, 1'b0);
        pulses = 0;
        for (int p = 1; p <= 2; p++) begin
            logic [4:0] bounce_pat;
            bounce_pat = 5'b10110;
            for (int k = 4; k >= 0; k--) begin
                in = bounce_pat[k];
                step();
            end
            in = 1'b1;
            for (int k = 0; k < 12; k++) step();
            $display("press %0d: out=%b pulses=%0d", p, out, pulses);
            check_int($sformatf("chain_press%0d_pulses", p), pulses, p);
            for (int k = 4; k >= 0; k--) begin
                in = ~bounce_pat[k];
                step();
            end
            in = 1'b0;
            for (int k = 0; k < 12; k++) step();
            $display("release %0d: out=%b pulses=%0d", p, out, pulses);
            check_int($sformatf("chain_release%0d_pulses", p), pulses, p);
            check($sformatf("chain_release%0d_out", p), out, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 50000, number of consecutive synchronized-stable cycles required to accept a level change (1 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 16, stability counter width; SHALL satisfy 1 <= STABLE_CYCLES <= 2^CNT_W - 1.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 in  input  1  raw asynchronous mechanical button level, bouncing.
REQ-006 out  output  1  debounced, glitch-free level; registered; feeds the downstream edge detector's in.
REQ-007 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-008 in SHALL pass through a two-flop synchronizer; only the second flop (in_s) is used by any other logic.
REQ-009 Control SHALL be a four-state FSM: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-010 LOW: in_s=1 -> RISE_CHK, cnt<=0; else stay.
REQ-011 RISE_CHK: in_s=0 -> LOW, cnt<=0 (bounce abort); in_s=1 and cnt=STABLE_CYCLES-1 -> HIGH, cnt<=0; otherwise cnt<=cnt+1.
REQ-012 HIGH: in_s=0 -> FALL_CHK, cnt<=0; else stay.
REQ-013 FALL_CHK: in_s=1 -> HIGH, cnt<=0; in_s=0 and cnt=STABLE_CYCLES-1 -> LOW, cnt<=0; otherwise cnt<=cnt+1.
REQ-014 out SHALL be 1 exactly in states HIGH and FALL_CHK, registered (no combinational path from in to out).
REQ-015 busy SHALL be 1 exactly in states RISE_CHK and FALL_CHK, registered.
REQ-016 Latency: a clean step on in (held stable) SHALL appear on out exactly STABLE_CYCLES+3 rising clk edges later.
REQ-017 Any in pulse or gap whose synchronized duration is <= STABLE_CYCLES cycles SHALL leave out unchanged.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 out SHALL change at most once per STABLE_CYCLES+1 cycles; never toggles twice without an intervening qualification.
REQ-020 STABLE_CYCLES=1: a level accepted after one confirming cycle in *_CHK; no other behaviour differs.

Reset
REQ-021 rst=0 SHALL immediately (asynchronously) force synchronizer flops to 0, state LOW, cnt 0, out 0, busy 0.
REQ-022 Reset asserted mid-qualification SHALL discard the partial count; no out pulse produced.
REQ-023 After rst release with in held 1, out SHALL rise STABLE_CYCLES+3 edges later (treated as a fresh rising step).

Structure
REQ-024 FSM state encoding constants (LOW, RISE_CHK, HIGH, FALL_CHK, 2-bit) SHALL live in the project's shared definitions package; no other typedefs exported.
REQ-025 Synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q; active-low async reset to 0), reusable for other asynchronous inputs.
REQ-026 Counter and FSM SHALL remain in button_debouncer; no multi-clock logic.

Verification (STABLE_CYCLES=4, CNT_W=3)
REQ-027 Reset: rst=0 with in=1 -> out=0, busy=0 immediately, independent of clk.
REQ-028 Clean rise: in 0->1 held -> busy high from edge 3 to edge 6, out=1 at edge 7, stays 1.
REQ-029 Bounce: in 1 for 3 cycles, 0 for 2, 1 for 2, then 0 held -> out never rises; busy pulses, returns 0.
REQ-030 Clean fall after REQ-028: in 1->0 held -> out=0 exactly 7 edges later.
REQ-031 Reset mid-RISE_CHK (rst=0 at edge 5 for 2 cycles, in held 1) -> out stays 0, then rises 7 edges after rst release.
REQ-032 Chain check: button_debouncer.out into downstream edge detector, bouncing press -> exactly one one-cycle pulse per press.
